// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD capture path: default geometry,
// capture states and the BGP palette lookup.
package lcd_pkg;

    localparam int LCD_W              = 160;
    localparam int LCD_H              = 144;
    localparam int LCD_BYTES_PER_LINE = LCD_W / 4;

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_ACTIVE = 2'd1,
        S_VBLANK = 2'd2
    } capture_state_t;

    // Colour index c selects pal[2c+1:2c].
    function automatic logic [1:0] pal_map(input logic [7:0] pal, input logic [1:0] c);
        case (c)
            2'd0:    pal_map = pal[1:0];
            2'd1:    pal_map = pal[3:2];
            2'd2:    pal_map = pal[5:4];
            default: pal_map = pal[7:6];
        endcase
    endfunction

endpackage

// File: rtl/pixel_packer.sv
// Packs 2-bit pixels four to a byte, first pixel in bits [7:6]; a flush
// emits a partial group zero-padded in the low bits.
module pixel_packer (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       push,
    input  logic       flush,
    input  logic [1:0] color,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    logic [7:0] sr;
    logic [1:0] cnt;
    logic [7:0] sr_n;
    logic [2:0] cnt_n;

    // A pixel arriving with a flush is packed first, then the group is closed.
    always_comb begin
        sr_n       = push ? {sr[5:0], color} : sr;
        cnt_n      = {1'b0, cnt} + {2'b00, push};
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        if (cnt_n == 3'd4) begin
            byte_valid = 1'b1;
            byte_data  = sr_n;
        end else if (flush && cnt_n != 3'd0) begin
            byte_valid = 1'b1;
            byte_data  = sr_n << (4'd8 - {cnt_n, 1'b0});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 2'd0;
        end else if (clr || byte_valid) begin
            cnt <= 2'd0;
        end else begin
            cnt <= cnt_n[1:0];
        end
    end

    always_ff @(posedge clk) begin
        sr <= sr_n;
    end

endmodule

// File: rtl/lcd_capture.sv
// Captures the PPU LCD stream into a double-banked framebuffer of packed 2-bit pixels.
// Define LCD_CAPTURE_PALETTE_EN to store bgp-mapped colours instead of raw indices.
module lcd_capture
    import lcd_pkg::*;
#(
    parameter int WIDTH  = LCD_W,
    parameter int HEIGHT = LCD_H
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lcd_pixel,
    input  logic [1:0]  lcd_color,
    input  logic        lcd_hsync,
    input  logic        lcd_vsync,
    input  logic [7:0]  bgp,
    input  logic        err_clr,
    output logic [12:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        fb_we,
    output logic        fb_bank,
    output logic        disp_bank,
    output logic        frame_done,
    output logic        synced,
    output logic        err_short,
    output logic        err_long
);

    localparam int            XW    = $clog2(WIDTH + 1);
    localparam int            YW    = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT);
    localparam logic [12:0]   BPL   = 13'(WIDTH / 4);

    capture_state_t state;
    logic           hs_q, vs_q;
    logic [XW-1:0]  x, x_after;
    logic [YW-1:0]  y, y_after;
    logic [12:0]    addr, line_base;
    logic           frame_bad;
    logic           hs_rise, vs_rise, vs_fall, active, start;
    logic           pix_ok, pix_bad, take, overflow;
    logic           line_end, frame_end, short_set, long_set, frame_ok, wr;
    logic [1:0]     color;
    logic           byte_valid;
    logic [7:0]     byte_data;

`ifdef LCD_CAPTURE_PALETTE_EN
    assign color = pal_map(bgp, lcd_color);
`else
    logic unused_bgp;
    assign unused_bgp = ^bgp;
    assign color      = lcd_color;
`endif

    assign disp_bank = ~fb_bank;

    // A pixel on the hsync rising edge still belongs to the line it closes.
    always_comb begin
        hs_rise   = lcd_hsync & ~hs_q;
        vs_rise   = lcd_vsync & ~vs_q;
        vs_fall   = ~lcd_vsync & vs_q;
        active    = (state == S_ACTIVE);
        start     = vs_fall & ~active;
        pix_ok    = lcd_pixel & (~lcd_hsync | hs_rise) & ~lcd_vsync;
        take      = active & pix_ok & (x < X_MAX);
        overflow  = active & pix_ok & (x == X_MAX);
        pix_bad   = (active & lcd_pixel & ~pix_ok) |
                    ((state == S_VBLANK) & lcd_pixel & (lcd_hsync | lcd_vsync));
        x_after   = take ? x + XW'(1) : x;
        line_end  = active & (hs_rise | (vs_rise & (x_after != '0)));
        frame_end = active & vs_rise;
        y_after   = (line_end && y != Y_MAX) ? y + YW'(1) : y;
        short_set = (line_end & (x_after < X_MAX)) | (frame_end & (y_after < Y_MAX));
        long_set  = overflow | pix_bad | (line_end & (y == Y_MAX));
        frame_ok  = frame_end & ~(frame_bad | short_set | long_set) & (y_after == Y_MAX);
        wr        = byte_valid & (y != Y_MAX);
    end

    pixel_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start),
        .push       (take),
        .flush      (line_end),
        .color      (color),
        .byte_valid (byte_valid),
        .byte_data  (byte_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_SYNC;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            x          <= '0;
            y          <= '0;
            addr       <= 13'd0;
            line_base  <= 13'd0;
            frame_bad  <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= 13'd0;
            fb_data    <= 8'h00;
            fb_bank    <= 1'b0;
            frame_done <= 1'b0;
            synced     <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
        end else begin
            hs_q       <= lcd_hsync;
            vs_q       <= lcd_vsync;
            fb_we      <= wr;
            frame_done <= frame_ok;
            if (wr) begin
                fb_addr <= addr;
                fb_data <= byte_data;
            end
            if (frame_ok) fb_bank <= ~fb_bank;
            err_short <= short_set | (err_short & ~err_clr);
            err_long  <= long_set | (err_long & ~err_clr);

            if (start) begin
                state     <= S_ACTIVE;
                synced    <= 1'b1;
                x         <= '0;
                y         <= '0;
                addr      <= 13'd0;
                line_base <= 13'd0;
                frame_bad <= 1'b0;
            end else if (active) begin
                frame_bad <= frame_bad | short_set | long_set;
                if (line_end) begin
                    x <= '0;
                    y <= y_after;
                    // Lines past the bottom are discarded, so the base stays put.
                    if (y != Y_MAX) begin
                        addr      <= line_base + BPL;
                        line_base <= line_base + BPL;
                    end
                end else begin
                    x <= x_after;
                    if (wr) addr <= addr + 13'd1;
                end
                if (frame_end) state <= S_VBLANK;
            end
        end
    end

endmodule
